// File: rtl/snake_pkg.sv
// Shared constants and state encoding for the snake game pixel path.
package snake_pkg;

    // Visible screen geometry.
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    // 3-bit RGB colour constants (one bit per channel).
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

    // Tile plotter state encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } plot_state_t;

endpackage

// File: rtl/snake_xy_sweep.sv
// Nested x/y raster counter: x is the inner loop, y the outer loop.
// 'start' presents the origin in the same cycle and advances past it;
// 'step' advances from the current position. The counter wraps back to
// the origin after the last position so it is always parked at (0,0).
module snake_xy_sweep #(
    parameter int W   = 160,
    parameter int H   = 120,
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           step,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(H - 1);

    logic [X_W-1:0] x_reg;
    logic [Y_W-1:0] y_reg;

    // Current position; a start request always reads as the origin.
    assign x    = start ? '0 : x_reg;
    assign y    = start ? '0 : y_reg;
    assign last = (x == X_LAST) && (y == Y_LAST);

    // Raster position register, advanced on start or step.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg <= '0;
            y_reg <= '0;
        end else if (start || step) begin
            if (x == X_LAST) begin
                x_reg <= '0;
                y_reg <= (y == Y_LAST) ? '0 : y + Y_W'(1);
            end else begin
                x_reg <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_tile_plotter.sv
// Pixel-side responder for snake drawing commands: expands a full-screen
// clear or a 2x2 tile draw into per-pixel VGA writes.
// Optional feature: define PLOT_BORDER_EN to paint the screen edge in
// BORDER_COLOUR during a clear (timing is unchanged).
module snake_tile_plotter #(
    parameter int               SCREEN_W      = snake_pkg::SCREEN_W,
    parameter int               SCREEN_H      = snake_pkg::SCREEN_H,
    parameter int               X_W           = 8,
    parameter int               Y_W           = 7,
    parameter int               COL_W         = 3,
    parameter logic [COL_W-1:0] BORDER_COLOUR = snake_pkg::WHITE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_req,
    input  logic             draw_req,
    input  logic [X_W-1:0]   draw_x,
    input  logic [Y_W-1:0]   draw_y,
    input  logic [COL_W-1:0] draw_colour,
    output logic             busy,
    output logic             draw_done,
    output logic             clear_done,
    output logic [X_W-1:0]   vga_x,
    output logic [Y_W-1:0]   vga_y,
    output logic [COL_W-1:0] vga_colour,
    output logic             vga_plot
);

    import snake_pkg::*;

    // Screen limits at the widened (no-wrap) pixel width.
    localparam logic [X_W:0] X_LIMIT = (X_W + 1)'(SCREEN_W);
    localparam logic [Y_W:0] Y_LIMIT = (Y_W + 1)'(SCREEN_H);

    plot_state_t      state_reg, state_next;
    logic [1:0]       sub_reg, sub_next;
    logic [X_W-1:0]   tile_x_reg, tile_x_next;
    logic [Y_W-1:0]   tile_y_reg, tile_y_next;
    logic [COL_W-1:0] tile_colour_reg, tile_colour_next;
    logic             clear_tail_reg, clear_tail_next;
    logic             op_clear_reg, op_clear_next;

    logic [X_W-1:0]   vga_x_reg, vga_x_next;
    logic [Y_W-1:0]   vga_y_reg, vga_y_next;
    logic [COL_W-1:0] vga_colour_reg, vga_colour_next;
    logic             vga_plot_reg, vga_plot_next;

    // Sweep interface.
    logic             sweep_start, sweep_step, sweep_last;
    logic [X_W-1:0]   sweep_x;
    logic [Y_W-1:0]   sweep_y;

    // Candidate pixel for this cycle, before clipping.
    logic             emit;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [1:0]       offset;
    logic [COL_W-1:0] emit_colour;
    logic [COL_W-1:0] clear_colour;
    logic [X_W:0]     px_x_wide;
    logic [Y_W:0]     px_y_wide;
    logic             in_bounds;

    snake_xy_sweep #(
        .W   (SCREEN_W),
        .H   (SCREEN_H),
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_sweep (
        .clk   (clk),
        .rst   (rst),
        .start (sweep_start),
        .step  (sweep_step),
        .x     (sweep_x),
        .y     (sweep_y),
        .last  (sweep_last)
    );

`ifdef PLOT_BORDER_EN
    // Edge pixels of the screen get the border colour, everything else black.
    assign clear_colour = ((sweep_x == '0) || (sweep_x == X_W'(SCREEN_W - 1)) ||
                           (sweep_y == '0) || (sweep_y == Y_W'(SCREEN_H - 1)))
                          ? BORDER_COLOUR : '0;
`else
    assign clear_colour = '0;
`endif

    // Widened add so a tile near the edge clips instead of wrapping to 0.
    assign px_x_wide = {1'b0, base_x} + {{X_W{1'b0}}, offset[0]};
    assign px_y_wide = {1'b0, base_y} + {{Y_W{1'b0}}, offset[1]};
    assign in_bounds = (px_x_wide < X_LIMIT) && (px_y_wide < Y_LIMIT);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            sub_reg         <= '0;
            tile_x_reg      <= '0;
            tile_y_reg      <= '0;
            tile_colour_reg <= '0;
            clear_tail_reg  <= 1'b0;
            op_clear_reg    <= 1'b0;
            vga_x_reg       <= '0;
            vga_y_reg       <= '0;
            vga_colour_reg  <= '0;
            vga_plot_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sub_reg         <= sub_next;
            tile_x_reg      <= tile_x_next;
            tile_y_reg      <= tile_y_next;
            tile_colour_reg <= tile_colour_next;
            clear_tail_reg  <= clear_tail_next;
            op_clear_reg    <= op_clear_next;
            vga_x_reg       <= vga_x_next;
            vga_y_reg       <= vga_y_next;
            vga_colour_reg  <= vga_colour_next;
            vga_plot_reg    <= vga_plot_next;
        end
    end

    // Next-state logic: accept requests in IDLE and choose the pixel to emit.
    // The first pixel of an operation is emitted straight from the accept
    // cycle so it appears on the outputs one cycle after acceptance.
    always_comb begin
        state_next       = state_reg;
        sub_next         = sub_reg;
        tile_x_next      = tile_x_reg;
        tile_y_next      = tile_y_reg;
        tile_colour_next = tile_colour_reg;
        clear_tail_next  = clear_tail_reg;
        op_clear_next    = op_clear_reg;
        sweep_start      = 1'b0;
        sweep_step       = 1'b0;
        emit             = 1'b0;
        base_x           = tile_x_reg;
        base_y           = tile_y_reg;
        offset           = sub_reg;
        emit_colour      = tile_colour_reg;

        unique case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next      = CLEAR;
                    op_clear_next   = 1'b1;
                    clear_tail_next = 1'b0;
                    sweep_start     = 1'b1;
                    emit            = 1'b1;
                    base_x          = sweep_x;
                    base_y          = sweep_y;
                    offset          = 2'd0;
                    emit_colour     = clear_colour;
                end else if (draw_req) begin
                    state_next       = DRAW;
                    op_clear_next    = 1'b0;
                    tile_x_next      = draw_x;
                    tile_y_next      = draw_y;
                    tile_colour_next = draw_colour;
                    sub_next         = 2'd1;
                    emit             = 1'b1;
                    base_x           = draw_x;
                    base_y           = draw_y;
                    offset           = 2'd0;
                    emit_colour      = draw_colour;
                end
            end
            CLEAR: begin
                // One trailing cycle after the last pixel keeps clear timing
                // aligned with draw timing (done one cycle after last pixel).
                if (clear_tail_reg) begin
                    state_next      = DONE;
                    clear_tail_next = 1'b0;
                end else begin
                    sweep_step      = 1'b1;
                    emit            = 1'b1;
                    base_x          = sweep_x;
                    base_y          = sweep_y;
                    offset          = 2'd0;
                    emit_colour     = clear_colour;
                    clear_tail_next = sweep_last;
                end
            end
            DRAW: begin
                // sub counts 1,2,3 for the remaining pixels, then 0 = trailing cycle.
                if (sub_reg == 2'd0) begin
                    state_next = DONE;
                end else begin
                    emit     = 1'b1;
                    sub_next = sub_reg + 2'd1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output register update: clipped pixels consume a cycle but leave the
    // previous coordinates and colour on the bus.
    always_comb begin
        vga_x_next      = vga_x_reg;
        vga_y_next      = vga_y_reg;
        vga_colour_next = vga_colour_reg;
        vga_plot_next   = 1'b0;
        if (emit && in_bounds) begin
            vga_x_next      = px_x_wide[X_W-1:0];
            vga_y_next      = px_y_wide[Y_W-1:0];
            vga_colour_next = emit_colour;
            vga_plot_next   = 1'b1;
        end
    end

    assign busy       = (state_reg != IDLE);
    assign draw_done  = (state_reg == DONE) && !op_clear_reg;
    assign clear_done = (state_reg == DONE) &&  op_clear_reg;
    assign vga_x      = vga_x_reg;
    assign vga_y      = vga_y_reg;
    assign vga_colour = vga_colour_reg;
    assign vga_plot   = vga_plot_reg;

endmodule

// File: tb/tb_snake_tile_plotter.sv
// Testbench for snake_tile_plotter: stimulus pushes expected pixel/done
// events into a scoreboard queue; a monitor pops and compares them.
module tb_snake_tile_plotter;

    localparam logic [1:0] K_PIX   = 2'd0;
    localparam logic [1:0] K_DDONE = 2'd1;
    localparam logic [1:0] K_CDONE = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear_req = 1'b0;
    logic       draw_req = 1'b0;
    logic [7:0] draw_x = '0;
    logic [6:0] draw_y = '0;
    logic [2:0] draw_colour = '0;
    logic       busy, draw_done, clear_done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    ev_t sb_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    always #5 clk = ~clk;

    snake_tile_plotter dut (
        .clk         (clk),
        .rst         (rst),
        .clear_req   (clear_req),
        .draw_req    (draw_req),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_colour (draw_colour),
        .busy        (busy),
        .draw_done   (draw_done),
        .clear_done  (clear_done),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot)
    );

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_pix(int x, int y, int c);
        ev_t e;
        if (x < 160 && y < 120) begin
            e.kind = K_PIX; e.x = 8'(x); e.y = 7'(y); e.c = 3'(c);
            sb_q.push_back(e);
        end
    endtask

    task automatic push_ev(logic [1:0] kind);
        ev_t e;
        e = '0;
        e.kind = kind;
        sb_q.push_back(e);
    endtask

    function automatic int clear_colour_model(int x, int y);
`ifdef PLOT_BORDER_EN
        if (x == 0 || x == 159 || y == 0 || y == 119) return 7;
`endif
        return 0;
    endfunction

    // Monitor: every observed pixel strobe or done pulse must match the queue head.
    task automatic pop_check(ev_t obs);
        ev_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got 0x%0h required none", int'(obs));
        end else begin
            e = sb_q.pop_front();
            check("event", int'(obs), int'(e));
        end
    endtask

    always @(negedge clk) begin
        ev_t obs;
        if (vga_plot === 1'b1) begin
            obs.kind = K_PIX; obs.x = vga_x; obs.y = vga_y; obs.c = vga_colour;
            pop_check(obs);
        end
        if (draw_done === 1'b1) begin
            obs = '0; obs.kind = K_DDONE;
            pop_check(obs);
        end
        if (clear_done === 1'b1) begin
            obs = '0; obs.kind = K_CDONE;
            pop_check(obs);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 30000) begin
            tick();
            n++;
        end
        check("idle_wait_timeout", int'(busy === 1'b0), 1);
    endtask

    // Single tile draw with a cycle-by-cycle timing check from T+1 to T+6.
    task automatic run_draw(int x, int y, int c, string tag);
        int lx = -1, ly = -1;
        wait_idle();
        draw_x = 8'(x); draw_y = 7'(y); draw_colour = 3'(c); draw_req = 1'b1;
        for (int k = 0; k < 4; k++) push_pix(x + (k % 2), y + (k / 2), c);
        push_ev(K_DDONE);
        tick();
        draw_req = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            int px, py, exp_plot;
            @(negedge clk);
            px = x + ((i - 1) % 2);
            py = y + ((i - 1) / 2);
            exp_plot = (i <= 4 && px < 160 && py < 120) ? 1 : 0;
            check($sformatf("%s_busy_T+%0d", tag, i), int'(busy), (i <= 5) ? 1 : 0);
            check($sformatf("%s_plot_T+%0d", tag, i), int'(vga_plot), exp_plot);
            check($sformatf("%s_ddone_T+%0d", tag, i), int'(draw_done), (i == 5) ? 1 : 0);
            if (exp_plot == 1) begin
                lx = px; ly = py;
            end else if (lx >= 0) begin
                check($sformatf("%s_hold_T+%0d", tag, i), int'({vga_x, vga_y}), (lx << 7) | ly);
            end
        end
        $display("draw %s at (%0d,%0d) colour %0d complete", tag, x, y, c);
    endtask

    task automatic push_clear();
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                push_pix(xx, yy, clear_colour_model(xx, yy));
        push_ev(K_CDONE);
    endtask

    // Counts negedges from T+1 until clear_done; expects it at T+19201.
    task automatic wait_clear_done(string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (clear_done !== 1'b1 && n < 20000);
        check({tag, "_clear_done_cycle"}, n, 19201);
        check({tag, "_busy_in_done"}, int'(busy), 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        rst = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("reset_busy", int'(busy), 0);
        check("reset_outputs", int'({vga_plot, draw_done, clear_done, vga_x, vga_y, vga_colour}), 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: basic draw.
        run_draw(10, 20, 3'b100, "draw1");

        // 2 / 6: full clear (border colours applied when PLOT_BORDER_EN is defined).
        wait_idle();
        push_clear();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        wait_clear_done("clear1");
        @(negedge clk);
        check("clear1_busy_after", int'(busy), 0);
        check("clear1_queue_drained", sb_q.size(), 0);
        $display("clear1 complete");

        // 3: corner tile, three of four pixels clipped.
        run_draw(159, 119, 3'b010, "corner");

        // 4: clear and draw together -> clear first, then draw.
        wait_idle();
        push_clear();
        for (int k = 0; k < 4; k++) push_pix(30 + (k % 2), 40 + (k / 2), 3'b010);
        push_ev(K_DDONE);
        clear_req = 1'b1; draw_req = 1'b1;
        draw_x = 8'd30; draw_y = 7'd40; draw_colour = 3'b010;
        tick();
        clear_req = 1'b0;
        wait_clear_done("both");
        tick();
        tick();
        draw_req = 1'b0;
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (draw_done !== 1'b1 && n < 50);
            check("both_draw_done_cycle", n, 5);
        end
        @(negedge clk);
        check("both_queue_drained", sb_q.size(), 0);
        $display("clear+draw pair complete");

        // 5: reset during the third cycle of a draw.
        wait_idle();
        draw_x = 8'd50; draw_y = 7'd60; draw_colour = 3'b100; draw_req = 1'b1;
        for (int k = 0; k < 3; k++) push_pix(50 + (k % 2), 60 + (k / 2), 3'b100);
        tick();
        draw_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", int'(busy), 0);
        check("abort_outputs", int'({vga_plot, draw_done, clear_done, vga_x, vga_y, vga_colour}), 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("abort_no_done_%0d", i), int'({busy, draw_done}), 0);
        end
        check("abort_queue_drained", sb_q.size(), 0);
        $display("aborted draw complete");

        // A fresh draw after the abort still works.
        run_draw(0, 0, 3'b111, "post_abort");
        @(negedge clk);
        check("final_queue_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
